seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Multiplexed N-digit 7-segment display driver for the egg timer front panel. It replaces per-digit static decoding with one time-shared segment bus and per-digit anode enables. It double-buffers the displayed value so updates never tear mid-frame, blanks leading zeros on request, and inserts a dark cycle between digits to suppress ghosting. It sits between the countdown/BCD datapath and the board's segment and anode pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned, legal range 1..8.
- `REFRESH_DIV`, 100000: clock cycles per digit slot, including the dark cycle; must be ≥2.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `value` in 4*NUM_DIGITS: packed nibbles; nibble 0 (bits 3:0) is the rightmost/least significant digit.
- `load` in 1: when high, captures `value` into the pending register that cycle.
- `dp_in` in NUM_DIGITS: decimal point request per digit; sampled live, not buffered.
- `blank_lz` in 1: leading-zero blanking enable; sampled live.
- `seg` out 7: active-low segments; bit0=a through bit6=g.
- `dp` out 1: active-low decimal point.
- `an` out NUM_DIGITS: active-low digit enables, one-hot-low or all high.
- `frame_start` out 1: one-cycle pulse marking the start of a new frame.

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1 and then wraps. `tick` = (`cnt` == REFRESH_DIV-1).
- On `tick`, digit index `idx` increments, wrapping NUM_DIGITS-1 → 0. When NUM_DIGITS=1, `idx` stays 0.
- Pending register: `pend <= value` on `load`. Display register `disp` updates only at the frame wrap, i.e. on `tick` with `idx`==NUM_DIGITS-1:
  - if `load` is high in that same cycle, `disp <= value` (bypass);
  - otherwise `disp <= pend`.
- Multiple `load`s within a frame: the last one wins.
- Nibble decode for codes 0–9 uses standard patterns, e.g.:
  - 0 → 7'b1000000
  - 1 → 7'b1111001
  - 8 → 7'b0000000
  - 9 → 7'b0010000
- Codes 10–15 decode to blank (7'b1111111), unless the hex feature is compiled in (see Configuration).
- Leading-zero blanking applies to digit i when `blank_lz`=1, i≠0, and nibbles i..NUM_DIGITS-1 of `disp` are all 0. In that case:
  - `seg` = blank;
  - the `an` enable is still driven;
  - `dp` still follows `dp_in[i]`.
- Digit 0 is never blanked by LZ.
- `dp` = ~`dp_in[idx]` while a digit is enabled; 1 during dark cycles.

## Timing
- Reset values:
  - `cnt`=0, `idx`=0, `pend`=0, `disp`=0;
  - `an` = all 1s, `seg`=7'b1111111, `dp`=1, `frame_start`=0.
- All outputs are registered. `an`/`seg`/`dp` reflect `idx` and `disp` as of the previous edge, so latency from an `idx` change to the pins is one cycle.
- Dark cycle: in the cycle following a `tick` edge, `an` = all 1s and `seg`/`dp` are blank. The new digit appears on the next cycle.
- Digit duty cycle: each digit is lit REFRESH_DIV-1 of every REFRESH_DIV cycles. Frame period is NUM_DIGITS*REFRESH_DIV cycles.
- First cycle after `reset` deasserts: outputs are still at reset values, which serves as the dark cycle. Digit 0 is lit from the second cycle.
- `frame_start` is high during the dark cycle that precedes digit 0, aligned with the `disp` update. It does not pulse for the post-reset start.
- A `load` at cycle t becomes visible on the pins at the first digit-0 lit cycle after the next frame wrap at or after t.
- `reset` mid-frame: all state returns to reset values on the next edge; the `pend` contents are discarded.

## Configuration
- `SEG7_HEX_EN` defined: codes 10–15 decode to A, b, C, d, E, F:
  - A → 7'b0001000
  - b → 7'b0000011
  - C → 7'b1000110
  - d → 7'b0100001
  - E → 7'b0000110
  - F → 7'b0001110
- `SEG7_HEX_EN` undefined: codes 10–15 decode to blank.
- LZ blanking treats only the value 0 as a leading zero in both builds.

## Structure
- Package `seg7_pkg` holds:
  - `SEG_BLANK`;
  - the digit pattern constants;
  - the active-low helper `AN_OFF`;
  - the `IDX_W` = max(1, $clog2(NUM_DIGITS)) helper function.
- Sub-module `seg7_decode` is a combinational nibble → seg[6:0] decoder, with the hex case under `SEG7_HEX_EN`.
- All registers and scanning stay in `seg7_scan_driver`.

## Test plan
Bench settings: NUM_DIGITS=4, REFRESH_DIV=4.
- Reset, `value`=16'h1234 loaded once:
  - digit 0 (an=4'b1110) shows "4" (7'b0011001);
  - order 0,1,2,3 repeats every 16 cycles;
  - exactly one all-high `an` cycle between digits.
- `value`=16'h0007 with `blank_lz`=1:
  - digits 1–3 show `seg`=7'b1111111 with `an` still stepping;
  - with `blank_lz`=0 they show "0".
- Tear-free update: `load` 16'h1111 at mid-frame, then `load` 16'h2222 before the wrap:
  - the current frame stays on the old value;
  - the next frame shows all "2";
  - `frame_start` pulses once per 16 cycles.
- `load` coincident with the wrap tick: the bypass value is shown starting with the next frame's digit 0.
- Code 4'hA on digit 0:
  - blank without `SEG7_HEX_EN`;
  - 7'b0001000 with it.
- `dp_in`=4'b0100: `dp`=0 only while an=4'b1011. Asserting `reset` mid-frame returns all outputs to reset values on the next edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: active-low segment patterns,
// the anode-off helper and the digit-index width function. SEG7_HEX_EN adds the A..F patterns.
package seg7_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;

`ifdef SEG7_HEX_EN
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
`endif

  // Widest legal display is 8 digits; callers slice to their own width.
  localparam logic [7:0] AN_OFF = 8'hFF;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle between the countdown/BCD datapath (master) and the scan driver (slave),
// carrying the value/load/control inputs and the registered pin outputs.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output value,
    output load,
    output dp_in,
    output blank_lz,
    input  seg,
    input  dp,
    input  an,
    input  frame_start
  );

  modport slave (
    input  value,
    input  load,
    input  dp_in,
    input  blank_lz,
    output seg,
    output dp,
    output an,
    output frame_start
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low segment decoder.
// Codes 10..15 are blank unless SEG7_HEX_EN is defined, which maps them to A b C d E F.
module seg7_decode
  import seg7_pkg::*;
(
  input  nibble_t nib_i,
  output seg_t    seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
`ifdef SEG7_HEX_EN
      4'd10:   seg_o = SEG_A;
      4'd11:   seg_o = SEG_B;
      4'd12:   seg_o = SEG_C;
      4'd13:   seg_o = SEG_D;
      4'd14:   seg_o = SEG_E;
      4'd15:   seg_o = SEG_F;
`endif
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-aligned double buffering,
// leading-zero blanking and a dark slot between digits. Hex glyphs via SEG7_HEX_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input logic               clk,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      pend_q, pend_d;
  logic [VAL_W-1:0]      disp_q, disp_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_start_q, frame_start_d;

  logic                  tick;
  logic                  wrap;
  nibble_t               nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_zero;
  logic [NUM_DIGITS-1:0] digit_sel;
  nibble_t               cur_nib;
  seg_t                  dec_seg;
  logic                  lz_blank;

  assign tick = (cnt_q == CNT_LAST);
  assign wrap = tick && (idx_q == IDX_LAST);

  // lz_zero[i] is set when digit i and every more significant digit are zero.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi]       = disp_q[4*gi +: 4];
    assign lz_zero[gi]   = (disp_q[VAL_W-1:4*gi] == '0);
    assign digit_sel[gi] = (idx_q == IDX_W'(gi));
  end

  assign cur_nib  = nib[idx_q];
  assign lz_blank = bus.blank_lz && (idx_q != '0) && lz_zero[idx_q];

  seg7_decode u_decode (
    .nib_i (cur_nib),
    .seg_o (dec_seg)
  );

  // Prescaler and digit index.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A load landing on the wrap cycle bypasses pend so it is not lost for a frame.
  always_comb begin
    pend_d = bus.load ? bus.value : pend_q;
    disp_d = disp_q;
    if (wrap) begin
      disp_d = bus.load ? bus.value : pend_q;
    end
  end

  // Pin drive: the slot after each tick edge is dark, otherwise the current digit.
  always_comb begin
    an_d          = AN_ALL_OFF;
    seg_d         = SEG_BLANK;
    dp_d          = 1'b1;
    frame_start_d = wrap;
    if (!tick) begin
      an_d  = ~digit_sel;
      seg_d = lz_blank ? SEG_BLANK : dec_seg;
      dp_d  = ~bus.dp_in[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      pend_q        <= '0;
      disp_q        <= '0;
      an_q          <= AN_ALL_OFF;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pend_q        <= pend_d;
      disp_q        <= disp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;

endmodule
